uart_reg_bank: RTL and testbench

Parametrised successor to the serial register decoder. Decodes command bytes from the UART receiver into a banked byte-register array. Adds a real bank-select register, configurable bank and register counts, an optional atomic (staged) byte-commit mode, and a sticky error flag for out-of-range commands. Sits between the UART receiver and the sound/control registers; it is clocked by the system clock, and uart_ready arrives from the UART domain.

---
 rtl/uart_reg_bank.sv | 84 ++++++++
 tb/tb_uart_reg_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bank.sv
// uart_reg_bank: decodes UART command bytes into a banked byte-register array
module uart_reg_bank #(
  parameter int BANKS = 4,
  parameter int REGS = 4,
  parameter int ATOMIC = 0,
  parameter int SYNC_STAGES = 2,
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                uart_byte,
  input  logic                      uart_ready,
  input  logic                      err_clear,
  output logic [BANKS*REGS*8-1:0]   reg_data,
  output logic [BANKS-1:0]          reg_event,
  output logic [BW-1:0]             bank_sel,
  output logic                      err_flag
);
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    edge_q;
  logic                    accept;
  logic [BANKS*REGS*8-1:0] data_q, data_d;
  logic [BANKS*REGS*4-1:0] stage_q, stage_d;
  logic [BANKS-1:0]        ev_q, ev_d;
  logic [BW-1:0]           bank_q, bank_d;
  logic                    err_q, err_d;
  logic [3:0]              dat;
  logic [1:0]              ridx;
  logic                    nib, bank_ok, reg_ok, top;
  int                      idx;
  assign accept = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign dat = uart_byte[3:0];
  assign ridx = uart_byte[6:5];
  assign nib = uart_byte[4];
  assign bank_ok = int'(dat) < BANKS;
  assign reg_ok = int'(ridx) < REGS;
  assign top = int'(ridx) == REGS - 1;
  assign idx = int'(bank_q) * REGS + int'(ridx);
  // Next-state decode of the accepted command; bank_sel used as it stood before the edge
  always_comb begin
    data_d = data_q;
    stage_d = stage_q;
    bank_d = bank_q;
    ev_d = '0;
    err_d = err_q & ~err_clear;
    if (accept && uart_byte[7]) begin
      bank_d = bank_ok ? dat[BW-1:0] : bank_q;
      err_d = err_d | ~bank_ok;
    end else if (accept && !reg_ok) begin
      err_d = 1'b1;
    end else if (accept && !nib && ATOMIC != 0) begin
      stage_d[idx*4 +: 4] = dat;
    end else if (accept && !nib) begin
      data_d[idx*8 +: 4] = dat;
    end else if (accept) begin
      data_d[idx*8 +: 8] = {dat, (ATOMIC != 0) ? stage_q[idx*4 +: 4] : data_q[idx*8 +: 4]};
      ev_d[bank_q] = top;
    end
  end
  // Synchroniser, rising-edge detector and register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      data_q <= '0;
      stage_q <= '0;
      ev_q <= '0;
      bank_q <= '0;
      err_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_ready};
      edge_q <= sync_q[SYNC_STAGES-1];
      data_q <= data_d;
      stage_q <= stage_d;
      ev_q <= ev_d;
      bank_q <= bank_d;
      err_q <= err_d;
    end
  end
  assign reg_data = data_q;
  assign reg_event = ev_q;
  assign bank_sel = bank_q;
  assign err_flag = err_q;
endmodule

// File: tb/tb_uart_reg_bank.sv
// tb_uart_reg_bank: scoreboard bench over three configurations (direct, atomic, two-register)
module tb_uart_reg_bank;
  logic clk = 0, rst_n = 0, uart_ready = 0, err_clear = 0;
  logic [7:0] uart_byte = 0;
  logic [127:0] r0, r1;
  logic [63:0] r2;
  logic [3:0] v0, v1, v2;
  logic [1:0] b0, b1, b2;
  logic e0, e1, e2;
  int checks = 0, failures = 0;
  typedef struct packed {
    logic [2:0][127:0] data;
    logic [2:0][3:0]   ev;
    logic [2:0][1:0]   bank;
    logic [2:0]        err;
  } snap_t;
  snap_t exp_q[$];
  logic [2:0][127:0] m_data;
  logic [2:0][63:0]  m_stage;
  logic [2:0][1:0]   m_bank;
  logic [2:0]        m_err;
  always #5 clk = ~clk;
  uart_reg_bank #(.BANKS(4), .REGS(4), .ATOMIC(0)) u0 (.clk(clk), .rst_n(rst_n), .uart_byte(uart_byte),
    .uart_ready(uart_ready), .err_clear(err_clear), .reg_data(r0), .reg_event(v0), .bank_sel(b0), .err_flag(e0));
  uart_reg_bank #(.BANKS(4), .REGS(4), .ATOMIC(1)) u1 (.clk(clk), .rst_n(rst_n), .uart_byte(uart_byte),
    .uart_ready(uart_ready), .err_clear(err_clear), .reg_data(r1), .reg_event(v1), .bank_sel(b1), .err_flag(e1));
  uart_reg_bank #(.BANKS(4), .REGS(2), .ATOMIC(0)) u2 (.clk(clk), .rst_n(rst_n), .uart_byte(uart_byte),
    .uart_ready(uart_ready), .err_clear(err_clear), .reg_data(r2), .reg_event(v2), .bank_sel(b2), .err_flag(e2));
  function automatic void model_reset();
    m_data = '0;
    m_stage = '0;
    m_bank = '0;
    m_err = '0;
  endfunction
  function automatic void model(input int d, input logic [7:0] b, input logic clr, output logic [3:0] ev);
    int regs = (d == 2) ? 2 : 4;
    int r = int'(b[6:5]);
    int idx = int'(m_bank[d]) * regs + r;
    ev = '0;
    m_err[d] = m_err[d] & ~clr;
    if (b[7]) begin
      if (b[3:0] < 4'd4) m_bank[d] = b[1:0];
      else m_err[d] = 1'b1;
    end else if (r >= regs) m_err[d] = 1'b1;
    else if (!b[4] && d == 1) m_stage[d][idx*4 +: 4] = b[3:0];
    else if (!b[4]) m_data[d][idx*8 +: 4] = b[3:0];
    else begin
      m_data[d][idx*8+4 +: 4] = b[3:0];
      if (d == 1) m_data[d][idx*8 +: 4] = m_stage[d][idx*4 +: 4];
      if (r == regs - 1) ev[m_bank[d]] = 1'b1;
    end
  endfunction
  function automatic snap_t take(input logic [2:0][3:0] ev);
    snap_t s;
    s.data = m_data;
    s.ev = ev;
    s.bank = m_bank;
    s.err = m_err;
    return s;
  endfunction
  function automatic snap_t obs();
    snap_t o;
    o.data[0] = r0;
    o.data[1] = r1;
    o.data[2] = {64'b0, r2};
    o.ev[0] = v0;
    o.ev[1] = v1;
    o.ev[2] = v2;
    o.bank[0] = b0;
    o.bank[1] = b1;
    o.bank[2] = b2;
    o.err = {e2, e1, e0};
    return o;
  endfunction
  // Drive one byte (releasing reset at the same time), then check the cycle before,
  // the accept edge, and hold+1 cycles after while uart_ready stays high
  task automatic send(input logic [7:0] b, input logic clr, input int hold);
    snap_t pre, e, x, o;
    logic [2:0][3:0] ev;
    pre = take('0);
    for (int d = 0; d < 3; d++) model(d, b, clr, ev[d]);
    exp_q.push_back(take(ev));
    @(negedge clk);
    uart_byte = b;
    uart_ready = 1;
    rst_n = 1;
    @(posedge clk);
    for (int ph = 0; ph < hold + 3; ph++) begin
      @(posedge clk);
      #1;
      err_clear = (ph == 0) && clr;
      if (ph == 1) e = exp_q.pop_front();
      x = (ph == 0) ? pre : e;
      if (ph > 1) x.ev = '0;
      o = obs();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (o.data[d] !== x.data[d] || o.ev[d] !== x.ev[d] || o.bank[d] !== x.bank[d] || o.err[d] !== x.err[d]) begin
          failures++;
          $display("FAIL sb byte=%h phase=%0d dut=%0d got data=%h ev=%b bank=%0d err=%b want data=%h ev=%b bank=%0d err=%b",
            b, ph, d, o.data[d], o.ev[d], o.bank[d], o.err[d], x.data[d], x.ev[d], x.bank[d], x.err[d]);
        end
      end
    end
    @(negedge clk);
    uart_ready = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic clear_err();
    @(negedge clk);
    err_clear = 1;
    @(posedge clk);
    #1;
    err_clear = 0;
    m_err = '0;
    checks++;
    if ({e2, e1, e0} !== 3'b000) begin
      failures++;
      $display("FAIL err_clear got %b want 000", {e2, e1, e0});
    end
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({r0, r1, r2, v0, v1, v2, b0, b1, b2, e0, e1, e2} !== '0) begin
      failures++;
      $display("FAIL reset_state got bank=%0d/%0d/%0d err=%b%b%b want all zero", b0, b1, b2, e0, e1, e2);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_write();
    send(8'h82, 0, 0);
    send(8'h6F, 0, 0);
    checks++;
    if (r0[95:88] !== 8'h0F || r1[95:88] !== 8'h00) begin
      failures++;
      $display("FAIL low_nibble got %h/%h want 0f/00", r0[95:88], r1[95:88]);
    end
    send(8'h7A, 0, 0);
    checks++;
    if (r0[95:88] !== 8'hAF || r1[95:88] !== 8'hAF || b0 !== 2'd2) begin
      failures++;
      $display("FAIL high_nibble got %h/%h bank=%0d want af/af bank=2", r0[95:88], r1[95:88], b0);
    end
    send(8'h7B, 0, 0);
    checks++;
    if (r1[95:88] !== 8'hBF) begin
      failures++;
      $display("FAIL stage_reuse got %h want bf", r1[95:88]);
    end
  endtask
  task automatic test_err();
    send(8'h85, 0, 0);
    checks++;
    if (b0 !== 2'd2 || e0 !== 1'b1) begin
      failures++;
      $display("FAIL bad_bank got bank=%0d err=%b want bank=2 err=1", b0, e0);
    end
    clear_err();
    send(8'h85, 1, 0);
    checks++;
    if (e0 !== 1'b1 || e1 !== 1'b1) begin
      failures++;
      $display("FAIL set_wins got %b%b want 11", e0, e1);
    end
  endtask
  task automatic test_regs2();
    clear_err();
    send(8'h5F, 0, 0);
    checks++;
    if (e2 !== 1'b1 || e0 !== 1'b0 || r2 !== 64'h0) begin
      failures++;
      $display("FAIL regs2_range got err2=%b err0=%b r2=%h want 1 0 0", e2, e0, r2);
    end
    send(8'h3C, 0, 0);
    checks++;
    if (r2[47:40] !== 8'hC0) begin
      failures++;
      $display("FAIL regs2_write got %h want c0", r2[47:40]);
    end
  endtask
  task automatic test_hold();
    send(8'h4A, 0, 100);
    checks++;
    if (r0[87:80] !== 8'hFA) begin
      failures++;
      $display("FAIL hold_write got %h want fa", r0[87:80]);
    end
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    uart_byte = 8'h91;
    uart_ready = 1;
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({r0, r1, r2, v0, v1, v2, b0, b1, b2, e0, e1, e2} !== '0) begin
      failures++;
      $display("FAIL async_reset got bank=%0d err=%b r0=%h want all zero", b0, e0, r0);
    end
    uart_ready = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({b0, b1, b2} !== 6'd0 || {r0, r1, r2} !== '0) begin
      failures++;
      $display("FAIL pending_discard got bank=%0d/%0d/%0d want 0/0/0", b0, b1, b2);
    end
  endtask
  task automatic test_reset_held();
    @(negedge clk);
    uart_byte = 8'h91;
    uart_ready = 1;
    @(posedge clk);
    #2;
    rst_n = 0;
    model_reset();
    send(8'h91, 0, 5);
    checks++;
    if (b0 !== 2'd1) begin
      failures++;
      $display("FAIL held_after_reset got bank=%0d want 1", b0);
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_write();
    test_err();
    test_regs2();
    test_hold();
    test_reset_mid();
    test_reset_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
